// File: rtl/riscv_definitions.sv
// Shared definitions for the fetch slice: bus word type and the NOP encoding
// shown to decode whenever no valid instruction is presented.
package riscv_definitions;

    typedef logic [31:0] dataBus_u;

    localparam dataBus_u INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response channel between fetch (master) and memory (slave).
interface instr_fetch_if;
    import riscv_definitions::*;

    logic     imem_req_valid;
    logic     imem_req_ready;
    dataBus_u imem_req_addr;
    logic     imem_rsp_valid;
    dataBus_u imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

endinterface

// File: rtl/fetch_tag_fifo.sv
// Synchronous FIFO of PC tags for requests in flight; each entry carries a stale bit
// that a redirect sets so wrong-path responses can be recognised at pop time.
module fetch_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [31:0]      push_tag,
    input  logic             pop,
    input  logic             flush_mark,
    output logic [31:0]      head_tag,
    output logic             head_stale,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]      tag_mem [DEPTH];
    logic [DEPTH-1:0] stale;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head_tag   = tag_mem[rd_ptr];
    assign head_stale = stale[rd_ptr];
    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // A tag pushed in the redirect cycle belongs to the old path, so it is born stale.
    always_ff @(posedge clk) begin
        if (flush_mark) stale <= '1;
        if (push) begin
            tag_mem[wr_ptr] <= push_tag;
            stale[wr_ptr]   <= flush_mark;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues word fetches under a credit limit, tags responses
// with their PC and squashes wrong-path responses after a taken branch.
module instr_fetch
    import riscv_definitions::*;
#(
    parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          branch_taken,
    input  dataBus_u      jump_addr,
    input  logic          stall,
    instr_fetch_if.master imem,
    output logic          instr_valid,
    output dataBus_u      instr,
    output logic [31:0]   instr_pc,
    output logic          misaligned
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [31:0]      pc;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] inflight_next;
    logic [CNT_W:0]   used;
    logic [31:0]      head_tag;
    logic             head_stale, fifo_full, fifo_empty;
    logic             accept, rsp, discard, flush;
    logic             unused_bits;

    assign unused_bits = jump_addr[0];

    // A stalled valid buffer holds a credit, so no response can arrive while it is held.
    assign used = {1'b0, fifo_count} + (CNT_W + 1)'(instr_valid && stall);

    assign imem.imem_req_valid = clk_en && !rst && !fifo_full
                                 && (used < (CNT_W + 1)'(MAX_OUTSTANDING));
    assign imem.imem_req_addr  = pc;

    assign accept  = imem.imem_req_valid && imem.imem_req_ready;
    assign rsp     = clk_en && imem.imem_rsp_valid && !fifo_empty;
    assign discard = (drop_cnt != '0) || head_stale;
    assign flush   = clk_en && branch_taken;

    assign inflight_next = fifo_count + CNT_W'(accept) - CNT_W'(rsp);

    fetch_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (accept),
        .push_tag   (pc),
        .pop        (rsp),
        .flush_mark (flush),
        .head_tag   (head_tag),
        .head_stale (head_stale),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_ADDR;
            drop_cnt    <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            misaligned  <= 1'b0;
        end else if (clk_en) begin
            misaligned <= branch_taken && jump_addr[1];
            if (branch_taken) begin
                // Everything still in flight after this edge is wrong-path.
                pc          <= {jump_addr[31:2], 2'b00};
                drop_cnt    <= inflight_next;
                instr_valid <= 1'b0;
                instr       <= INSTR_NOP;
            end else begin
                if (accept) pc <= pc + 32'd4;
                if (rsp && discard && drop_cnt != '0) drop_cnt <= drop_cnt - CNT_W'(1);
                if (rsp && !discard) begin
                    instr       <= imem.imem_rsp_data;
                    instr_pc    <= head_tag;
                    instr_valid <= 1'b1;
                end else if (!stall) begin
                    instr_valid <= 1'b0;
                    instr       <= INSTR_NOP;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a queue-based in-order memory whose response
// word is the request address XOR 32'h1357_0000.
module tb_instr_fetch;
    import riscv_definitions::*;

    logic        clk = 1'b0;
    logic        rst, clk_en, branch_taken, stall, mem_hold;
    dataBus_u    jump_addr;
    logic        instr_valid, misaligned;
    dataBus_u    instr;
    logic [31:0] instr_pc;

    logic [31:0] q[$];
    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_if imem ();

    instr_fetch #(
        .RESET_ADDR      (32'h0000_0000),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .branch_taken (branch_taken),
        .jump_addr    (jump_addr),
        .stall        (stall),
        .imem         (imem),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .misaligned   (misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        imem.imem_rsp_valid = clk_en && !rst && !mem_hold && !stall && (q.size() > 0);
        imem.imem_rsp_data  = (q.size() > 0) ? (q[0] ^ 32'h1357_0000) : 32'h0;
        #1;
    endtask

    task automatic cycle();
        logic        acc, fire, was_rst;
        logic [31:0] addr;
        settle();
        acc     = imem.imem_req_valid && imem.imem_req_ready;
        addr    = imem.imem_req_addr;
        fire    = imem.imem_rsp_valid;
        was_rst = rst;
        @(posedge clk);
        if (was_rst) q.delete();
        else begin
            if (fire) void'(q.pop_front());
            if (acc)  q.push_back(addr);
        end
        #1;
        settle();
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; branch_taken = 1'b0; stall = 1'b0; mem_hold = 1'b0;
        jump_addr = 32'h0; imem.imem_req_ready = 1'b1;
        cycle(); cycle();
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_mis", misaligned, 0);
        chk("rst_req_valid", imem.imem_req_valid, 0);

        // Sequential stream with 1-cycle memory
        rst = 1'b0; settle();
        chk("first_req_valid", imem.imem_req_valid, 1);
        chk("first_req_addr", imem.imem_req_addr, 32'h0);
        cycle();
        chk("c1_valid", instr_valid, 0);
        chk("c1_req_addr", imem.imem_req_addr, 32'h4);
        cycle();
        chk("c2_valid", instr_valid, 1);
        chk("c2_pc", instr_pc, 32'h0);
        chk("c2_instr", instr, 32'h1357_0000);
        chk("c2_req_addr", imem.imem_req_addr, 32'h8);
        cycle();
        chk("c3_pc", instr_pc, 32'h4);
        chk("c3_instr", instr, 32'h1357_0004);
        cycle();
        chk("c4_pc", instr_pc, 32'h8);

        // Stall three cycles with a full buffer
        stall = 1'b1; settle();
        chk("stall_req_valid", imem.imem_req_valid, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_valid", instr_valid, 1);
            chk("stall_pc", instr_pc, 32'h8);
            chk("stall_instr", instr, 32'h1357_0008);
            chk("stall_outstanding", q.size() <= 2, 1);
        end
        stall = 1'b0;
        cycle();
        chk("release_pc", instr_pc, 32'hC);
        chk("release_instr", instr, 32'h1357_000C);
        cycle();
        chk("release_pc2", instr_pc, 32'h10);

        // Redirect with two requests in flight
        mem_hold = 1'b1;
        cycle();
        chk("hold_valid", instr_valid, 0);
        chk("hold_req_valid", imem.imem_req_valid, 0);
        branch_taken = 1'b1; jump_addr = 32'h100;
        cycle();
        branch_taken = 1'b0;
        chk("br_req_addr", imem.imem_req_addr, 32'h100);
        chk("br_mis", misaligned, 0);
        mem_hold = 1'b0;
        cycle();
        chk("drop1_valid", instr_valid, 0);
        cycle();
        chk("drop2_valid", instr_valid, 0);
        cycle();
        chk("tgt_valid", instr_valid, 1);
        chk("tgt_pc", instr_pc, 32'h100);
        chk("tgt_instr", instr, 32'h1357_0100);

        // Misaligned target while a same-cycle request is accepted
        branch_taken = 1'b1; jump_addr = 32'h102;
        cycle();
        branch_taken = 1'b0;
        chk("mis_pulse", misaligned, 1);
        chk("mis_req_addr", imem.imem_req_addr, 32'h100);
        chk("mis_valid", instr_valid, 0);
        cycle();
        chk("mis_clear", misaligned, 0);
        chk("mis_drop_valid", instr_valid, 0);
        cycle();
        chk("mis_tgt_valid", instr_valid, 1);
        chk("mis_tgt_pc", instr_pc, 32'h100);

        // PC wrap at the top of the address space
        branch_taken = 1'b1; jump_addr = 32'hFFFF_FFFC;
        cycle();
        branch_taken = 1'b0;
        chk("wrap_addr_hi", imem.imem_req_addr, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_addr_0", imem.imem_req_addr, 32'h0);
        chk("wrap_drop_valid", instr_valid, 0);
        cycle();
        chk("wrap_valid", instr_valid, 1);
        chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", instr, 32'hECA8_FFFC);

        // Clock enable low freezes everything
        clk_en = 1'b0; settle();
        chk("cen_req_valid", imem.imem_req_valid, 0);
        cycle(); cycle();
        chk("cen_hold_pc", instr_pc, 32'hFFFF_FFFC);
        chk("cen_hold_valid", instr_valid, 1);
        chk("cen_hold_addr", imem.imem_req_addr, 32'h4);
        clk_en = 1'b1;
        cycle();
        chk("cen_resume_pc", instr_pc, 32'h0);

        // Memory not ready: PC must not advance
        imem.imem_req_ready = 1'b0;
        cycle();
        chk("nready_addr", imem.imem_req_addr, 32'h8);
        chk("nready_pc", instr_pc, 32'h4);
        imem.imem_req_ready = 1'b1;

        // Reset mid-stream with drops pending
        mem_hold = 1'b1;
        cycle(); cycle();
        branch_taken = 1'b1; jump_addr = 32'h202;
        cycle();
        branch_taken = 1'b0;
        chk("pre_rst_mis", misaligned, 1);
        rst = 1'b1; mem_hold = 1'b0;
        cycle();
        chk("mid_rst_valid", instr_valid, 0);
        chk("mid_rst_instr", instr, 0);
        chk("mid_rst_pc", instr_pc, 0);
        chk("mid_rst_mis", misaligned, 0);
        chk("mid_rst_req_valid", imem.imem_req_valid, 0);
        rst = 1'b0; settle();
        chk("restart_addr", imem.imem_req_addr, 32'h0);
        chk("restart_req_valid", imem.imem_req_valid, 1);
        cycle(); cycle();
        chk("restart_valid", instr_valid, 1);
        chk("restart_pc", instr_pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
